// File: rtl/bloom_window_builder.sv
// Sliding byte window builder: each accepted byte yields one window per length MIN..fill.
// Optional statistics counters are enabled with macro BLOOM_WINDOW_BUILDER_STAT_EN.
module bloom_window_builder #(
  parameter int BYTE_W         = 8,
  parameter int MAX_STR_SIZE   = 20,
  parameter int MIN_STR_SIZE   = 3,
  parameter int MAX_STR_SIZE_W = $clog2(MAX_STR_SIZE) + 1
) (
  input  logic                                   clk_i,
  input  logic                                   arst_i,
  input  logic [BYTE_W-1:0]                      data_i,
  input  logic                                   sop_i,
  input  logic                                   eop_i,
  input  logic                                   valid_i,
  output logic                                   ready_o,
  output logic [MAX_STR_SIZE-1:0][BYTE_W-1:0]    window_data_o,
  output logic [MAX_STR_SIZE_W-1:0]              window_valid_bytes_o,
`ifdef BLOOM_WINDOW_BUILDER_STAT_EN
  output logic [31:0]                            bytes_cnt_o,
  output logic [31:0]                            windows_cnt_o,
  input  logic                                   stat_clean_stb_i,
`endif
  input  logic                                   window_ready_i
);

  localparam logic [MAX_STR_SIZE_W-1:0] L_MAX = MAX_STR_SIZE_W'(MAX_STR_SIZE);
  localparam logic [MAX_STR_SIZE_W-1:0] L_MIN = MAX_STR_SIZE_W'(MIN_STR_SIZE);
  localparam logic [MAX_STR_SIZE_W-1:0] L_ONE = MAX_STR_SIZE_W'(1);

  typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

  state_t                              r_state;
  state_t                              w_state_nxt;
  logic [MAX_STR_SIZE-1:0][BYTE_W-1:0] r_sr;
  logic [MAX_STR_SIZE_W-1:0]           r_fill;
  logic [MAX_STR_SIZE_W-1:0]           r_len;
  logic [MAX_STR_SIZE_W-1:0]           w_fill_new;
  logic                                r_eop;
  logic                                r_ready;
  logic                                w_accept;
  logic                                w_xfer;
  logic                                w_last;

  assign ready_o              = r_ready;
  assign w_accept             = valid_i & r_ready;
  assign window_valid_bytes_o = (r_state == S_EMIT) ? r_len : '0;
  assign w_xfer               = (window_valid_bytes_o != '0) & window_ready_i;
  assign w_last               = (r_len == r_fill);

  // Fill value the incoming byte would produce
  always_comb begin
    w_fill_new = r_fill;
    if (sop_i) begin
      w_fill_new = L_ONE;
    end else if (r_fill >= L_MAX) begin
      w_fill_new = L_MAX;
    end else begin
      w_fill_new = r_fill + L_ONE;
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (w_fill_new >= L_MIN)) w_state_nxt = S_EMIT;
        else                                   w_state_nxt = S_IDLE;
      end
      S_EMIT: begin
        if (w_xfer && w_last) w_state_nxt = S_IDLE;
        else                  w_state_nxt = S_EMIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ready_o is held low during reset and follows the state from the first edge after it
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_IDLE);
    end
  end

  // Shift register, fill counter, window length and end-of-packet flag
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_sr   <= '0;
      r_fill <= '0;
      r_len  <= L_MIN;
      r_eop  <= 1'b0;
    end else if (w_accept) begin
      r_sr  <= {r_sr[MAX_STR_SIZE-2:0], data_i};
      r_eop <= eop_i;
      r_len <= L_MIN;
      // A closing byte too short to form a window ends the packet at once
      if (eop_i && (w_fill_new < L_MIN)) r_fill <= '0;
      else                               r_fill <= w_fill_new;
    end else if (w_xfer) begin
      if (w_last) begin
        r_len <= L_MIN;
        if (r_eop) r_fill <= '0;
        else       r_fill <= r_fill;
      end else begin
        r_len <= r_len + L_ONE;
      end
    end else begin
      r_len <= r_len;
    end
  end

  // Entries older than the current packet are masked to zero
  always_comb begin
    window_data_o = '0;
    for (int k = 0; k < MAX_STR_SIZE; k++) begin
      if (MAX_STR_SIZE_W'(k) < r_fill) window_data_o[k] = r_sr[k];
      else                             window_data_o[k] = '0;
    end
  end

`ifdef BLOOM_WINDOW_BUILDER_STAT_EN
  logic [31:0] r_bytes_cnt;
  logic [31:0] r_windows_cnt;

  // Statistics counters; a clear strobe beats a same-cycle increment
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_bytes_cnt   <= 32'd0;
      r_windows_cnt <= 32'd0;
    end else if (stat_clean_stb_i) begin
      r_bytes_cnt   <= 32'd0;
      r_windows_cnt <= 32'd0;
    end else begin
      if (w_accept) r_bytes_cnt   <= r_bytes_cnt + 32'd1;
      else          r_bytes_cnt   <= r_bytes_cnt;
      if (w_xfer)   r_windows_cnt <= r_windows_cnt + 32'd1;
      else          r_windows_cnt <= r_windows_cnt;
    end
  end

  assign bytes_cnt_o   = r_bytes_cnt;
  assign windows_cnt_o = r_windows_cnt;
`endif

endmodule

// File: tb/tb_bloom_window_builder.sv
// Scoreboard bench for bloom_window_builder: a packet-history model predicts every window.
module tb_bloom_window_builder;
  localparam int BW  = 8;
  localparam int MAX = 20;
  localparam int MIN = 3;
  localparam int LW  = $clog2(MAX) + 1;
  localparam int CW  = MAX * BW;

  logic                     clk = 1'b0;
  logic                     arst_i = 1'b1;
  logic [BW-1:0]            data_i = '0;
  logic                     sop_i = 1'b0;
  logic                     eop_i = 1'b0;
  logic                     valid_i = 1'b0;
  logic                     ready_o;
  logic [MAX-1:0][BW-1:0]   window_data_o;
  logic [LW-1:0]            window_valid_bytes_o;
  logic                     window_ready_i = 1'b0;
`ifdef BLOOM_WINDOW_BUILDER_STAT_EN
  logic [31:0]              bytes_cnt_o;
  logic [31:0]              windows_cnt_o;
  logic                     stat_clean_stb_i = 1'b0;
`endif

  bloom_window_builder #(.BYTE_W(BW), .MAX_STR_SIZE(MAX), .MIN_STR_SIZE(MIN)) dut (
    .clk_i(clk), .arst_i(arst_i), .data_i(data_i), .sop_i(sop_i), .eop_i(eop_i),
    .valid_i(valid_i), .ready_o(ready_o), .window_data_o(window_data_o),
    .window_valid_bytes_o(window_valid_bytes_o),
`ifdef BLOOM_WINDOW_BUILDER_STAT_EN
    .bytes_cnt_o(bytes_cnt_o), .windows_cnt_o(windows_cnt_o), .stat_clean_stb_i(stat_clean_stb_i),
`endif
    .window_ready_i(window_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] data;
    int            len;
  } win_t;

  win_t          exp_q[$];
  win_t          mon_e;
  logic [BW-1:0] hist[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            xfer_cnt = 0;
  bit            rdy_rand = 1'b0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the packet history (newest first) determines every window of a byte
  task automatic model_accept(input logic [BW-1:0] d, input bit sop, input bit eop);
    win_t w;
    int   fill;
    if (sop) hist.delete();
    hist.push_front(d);
    if (hist.size() > MAX) void'(hist.pop_back());
    fill   = hist.size();
    w.data = '0;
    for (int k = 0; k < fill; k++) w.data[k*BW +: BW] = hist[k];
    if (fill >= MIN) begin
      for (int l = MIN; l <= fill; l++) begin
        w.len = l;
        exp_q.push_back(w);
      end
    end
    if (eop) hist.delete();
  endtask

  // Monitor: every transferred window is popped from the scoreboard and compared
  initial forever begin
    @(negedge clk);
    if (!arst_i && (window_valid_bytes_o != '0) && window_ready_i) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_window: got len %0d expected none", window_valid_bytes_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("win_len", CW'(window_valid_bytes_o), CW'(mon_e.len));
        check("win_data", window_data_o, mon_e.data);
      end
    end
  end

  // Random downstream back-pressure when enabled
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_rand) window_ready_i = ($urandom_range(0, 3) != 0);
  end

  // Called at a negedge; returns at the negedge following acceptance
  task automatic send(input logic [BW-1:0] d, input bit sop, input bit eop);
    int t = 0;
    valid_i = 1'b1; data_i = d; sop_i = sop; eop_i = eop;
    while (!ready_o && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!ready_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got ready_o 0 expected 1");
    end else begin
      model_accept(d, sop, eop);
      @(negedge clk);
    end
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
  endtask

  task automatic set_rdy(input bit v, input bit rnd);
    @(posedge clk);
    #1;
    rdy_rand = rnd;
    window_ready_i = v;
    @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (!(exp_q.size() == 0 && ready_o) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0 || !ready_o) begin
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending windows expected 0", exp_q.size());
    end
  endtask

  initial begin
    logic [CW-1:0] snap_data;
    logic [LW-1:0] snap_len;
    logic [CW-1:0] ev;
    int            x0;
    int            t;
    int            plen;

    // Reset state
    #2;
    check("rst_ready", CW'(ready_o), CW'(1'b0));
    check("rst_len", CW'(window_valid_bytes_o), CW'(0));
    check("rst_data", window_data_o, '0);
    @(negedge clk); @(negedge clk);
    arst_i = 1'b0;
    #1 check("rel_ready_before_edge", CW'(ready_o), CW'(1'b0));
    @(posedge clk); #1;
    check("rel_ready_after_edge", CW'(ready_o), CW'(1'b1));
    @(negedge clk);

    // Packet "abcd"
    set_rdy(1'b1, 1'b0);
    x0 = xfer_cnt;
    send(8'h61, 1'b1, 1'b0);
    check("abcd_a_len", CW'(window_valid_bytes_o), CW'(0));
    check("abcd_a_ready", CW'(ready_o), CW'(1'b1));
    send(8'h62, 1'b0, 1'b0);
    check("abcd_b_len", CW'(window_valid_bytes_o), CW'(0));
    send(8'h63, 1'b0, 1'b0);
    check("abcd_c_len", CW'(window_valid_bytes_o), CW'(3));
    check("abcd_c_data", window_data_o, CW'(24'h616263));
    send(8'h64, 1'b0, 1'b1);
    check("abcd_d_data", window_data_o, CW'(32'h61626364));
    drain();
    check("abcd_windows", CW'(xfer_cnt - x0), CW'(3));
    check("abcd_fill0", window_data_o, '0);
`ifdef BLOOM_WINDOW_BUILDER_STAT_EN
    check("stat_bytes", CW'(bytes_cnt_o), CW'(4));
    check("stat_windows", CW'(windows_cnt_o), CW'(3));
`endif

    // Back-pressure: outputs hold while window_ready_i is low and no byte is taken
    set_rdy(1'b0, 1'b0);
    send(8'h70, 1'b1, 1'b0);
    send(8'h71, 1'b0, 1'b0);
    send(8'h72, 1'b0, 1'b0);
    snap_data = window_data_o;
    snap_len  = window_valid_bytes_o;
    check("stall_len_first", CW'(snap_len), CW'(3));
    valid_i = 1'b1; data_i = 8'h7a;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_len", CW'(window_valid_bytes_o), CW'(snap_len));
      check("stall_data", window_data_o, snap_data);
      check("stall_ready", CW'(ready_o), CW'(1'b0));
    end
    valid_i = 1'b0;
`ifdef BLOOM_WINDOW_BUILDER_STAT_EN
    @(posedge clk); #1;
    window_ready_i = 1'b1; stat_clean_stb_i = 1'b1;
    @(posedge clk); #1;
    stat_clean_stb_i = 1'b0;
    check("stat_clr_bytes", CW'(bytes_cnt_o), CW'(0));
    check("stat_clr_windows", CW'(windows_cnt_o), CW'(0));
    @(negedge clk);
`else
    set_rdy(1'b1, 1'b0);
`endif
    drain();

    // 25-byte packet: fill saturates, 1+2+..+18 windows then 18 per byte
    x0 = xfer_cnt;
    for (int i = 0; i < 25; i++) send(8'($urandom), i == 0, i == 24);
    drain();
    check("sat_windows", CW'(xfer_cnt - x0), CW'(261));

    // sop mid-packet restarts the fill at 1
    set_rdy(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) send(8'($urandom), i == 0, 1'b0);
    send(8'h5a, 1'b1, 1'b0);
    ev = '0; ev[7:0] = 8'h5a;
    check("sop_mid_len", CW'(window_valid_bytes_o), CW'(0));
    check("sop_mid_data", window_data_o, ev);
    send(8'h5b, 1'b0, 1'b1);
    drain();

    // Reset during emission at len 7
    set_rdy(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send(8'($urandom), i == 0, 1'b0);
    t = 0;
    while (window_valid_bytes_o != LW'(7) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("mid_emit_len7", CW'(window_valid_bytes_o), CW'(7));
    window_ready_i = 1'b0;
    #2 arst_i = 1'b1;
    #1;
    check("arst_len", CW'(window_valid_bytes_o), CW'(0));
    check("arst_ready", CW'(ready_o), CW'(1'b0));
    check("arst_data", window_data_o, '0);
    exp_q.delete();
    hist.delete();
    @(negedge clk); @(negedge clk);
    arst_i = 1'b0;
    #1 check("arst_rel_ready0", CW'(ready_o), CW'(1'b0));
    @(posedge clk); #1;
    check("arst_rel_ready1", CW'(ready_o), CW'(1'b1));
    check("arst_rel_len", CW'(window_valid_bytes_o), CW'(0));
    @(negedge clk);

    // Randomized packets with random back-pressure and gaps
    set_rdy(1'b1, 1'b1);
    for (int p = 0; p < 30; p++) begin
      plen = $urandom_range(1, 25);
      for (int i = 0; i < plen; i++) begin
        send(8'($urandom), (i == 0) || ($urandom_range(0, 15) == 0), i == plen - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bloom_window_builder.md
BLOOM_WINDOW_BUILDER -- requirements
Module: bloom_window_builder

Interface
REQ-001 SHALL have parameter BYTE_W, default 8: width of one stream byte.
REQ-002 SHALL have parameter MAX_STR_SIZE, default 20: longest searched string, which is also the window depth.
REQ-003 SHALL have parameter MIN_STR_SIZE, default 3: shortest searched string.
REQ-004 SHALL have parameter MAX_STR_SIZE_W, default $clog2(MAX_STR_SIZE)+1: width of the length fields.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port arst_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port data_i, input, BYTE_W bits: incoming stream byte.
REQ-008 SHALL have port sop_i, input, 1 bit: the byte is the first of its packet.
REQ-009 SHALL have port eop_i, input, 1 bit: the byte is the last of its packet.
REQ-010 SHALL have port valid_i, input, 1 bit: the byte is valid.
REQ-011 SHALL have port ready_o, output, 1 bit: byte accepted when valid_i and ready_o are both high.
REQ-012 SHALL have port window_data_o, output, MAX_STR_SIZE x BYTE_W bits: index 0 = newest byte, index k = byte accepted k beats earlier.
REQ-013 SHALL have port window_valid_bytes_o, output, MAX_STR_SIZE_W bits: length of the offered window; 0 = no window.
REQ-014 SHALL have port window_ready_i, input, 1 bit: downstream accepts the offered window.

Function
REQ-015 SHALL keep a MAX_STR_SIZE-deep byte shift register and a fill counter saturating at MAX_STR_SIZE.
REQ-016 SHALL implement two states: IDLE and EMIT.
- IDLE: ready_o=1, window_valid_bytes_o=0.
- EMIT: ready_o=0.
REQ-017 SHALL, on an accepted byte in IDLE:
- shift the byte into index 0;
- set fill to 1 if sop_i=1, otherwise to min(fill+1, MAX_STR_SIZE);
- latch eop_i.
REQ-018 SHALL move to EMIT with len=MIN_STR_SIZE on the next cycle if the new fill >= MIN_STR_SIZE; otherwise it stays in IDLE.
REQ-019 SHALL drive window_valid_bytes_o=len in EMIT; the first window appears 1 cycle after the byte is accepted.
REQ-020 SHALL treat a window as transferred when window_valid_bytes_o!=0 and window_ready_i=1.
REQ-021 SHALL, on each transfer, increment len; after the window with len=fill, it returns to IDLE.
- Number of windows per byte = fill-MIN_STR_SIZE+1.
REQ-022 SHALL hold window_data_o and window_valid_bytes_o stable while window_ready_i=0.
REQ-023 SHALL zero the fill counter when returning to IDLE after a byte with eop_i=1, or directly if that byte produced no window.
REQ-024 SHALL zero window_data_o entries at indices >= fill.
REQ-025 SHALL treat sop_i=1 while fill>0 as an implicit end of the previous packet: fill restarts at 1 and no error is raised.
REQ-026 SHALL emit a single window at a time; sustained throughput is one byte per (windows+1) cycles, and 1 byte/cycle only while fill < MIN_STR_SIZE.

Reset
REQ-027 SHALL, while arst_i is high, asynchronously force:
- state=IDLE, fill=0, len=MIN_STR_SIZE;
- shift register all zeros;
- ready_o=0, window_valid_bytes_o=0, window_data_o=0.
REQ-028 SHALL raise ready_o on the first clk_i edge after arst_i deasserts.
REQ-029 SHALL drop any in-progress emission on reset mid-EMIT; no residual window is offered after reset.

Configuration
REQ-030 SHALL, with macro BLOOM_WINDOW_BUILDER_STAT_EN defined, add:
- output bytes_cnt_o (32 bits): accepted bytes;
- output windows_cnt_o (32 bits): transferred windows;
- input stat_clean_stb_i (1 bit): synchronous clear, which wins over a same-cycle increment.
Both counters wrap at 2^32 and reset to 0.
REQ-031 SHALL, without BLOOM_WINDOW_BUILDER_STAT_EN, omit these ports and their logic entirely; behaviour is otherwise identical.

Verification
REQ-032 SHALL cover: packet "abcd" (sop on 'a', eop on 'd'), window_ready_i=1.
- No windows for 'a' and 'b'.
- After 'c': one window, len 3 = {c,b,a}.
- After 'd': len 3 {d,c,b}, then len 4 {d,c,b,a}.
- Fill is 0 afterwards.
REQ-033 SHALL cover: window_ready_i held 0 for 5 cycles during EMIT -> outputs stable, ready_o=0, no byte accepted.
REQ-034 SHALL cover: 25-byte packet -> fill saturates at 20; each byte after the 20th yields exactly 18 windows (len 3..20); the oldest bytes drop off index 19.
REQ-035 SHALL cover: sop_i=1 mid-packet after 10 bytes -> fill=1 and no window for that byte.
REQ-036 SHALL cover: arst_i pulsed during EMIT at len=7 -> window_valid_bytes_o=0 immediately; ready_o=1 after the first edge following release.
REQ-037 SHALL cover, with BLOOM_WINDOW_BUILDER_STAT_EN: the "abcd" packet -> bytes_cnt_o=4, windows_cnt_o=3; stat_clean_stb_i pulsed during a transfer -> both counters read 0.
